// File: rtl/modulo_ps2_tx_pkg.sv
// Shared PS/2 definitions: FSM state encoding, default cycle constants, frame length.
package modulo_ps2_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;
    localparam int unsigned FRAME_BITS         = 11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/modulo_ps2_tx_sync_edge.sv
// Two-flop synchronizer for one PS/2 line plus a falling-edge strobe on the synced value.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic meta;
    logic prev;

    // Idle PS/2 lines are pulled high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta  <= 1'b1;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            meta  <= line_in;
            level <= meta;
            prev  <= level;
        end
    end

    assign fall = prev & ~level;

endmodule

// File: rtl/modulo_ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, frame shift, ACK check, timeout.
module modulo_ps2_tx
    import modulo_ps2_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t          state, state_n;
    logic [7:0]      shreg, shreg_n;
    logic            parity, parity_n;
    logic [3:0]      bitcnt, bitcnt_n;
    logic [IW-1:0]   inh_cnt, inh_n;
    logic [TW-1:0]   tmo_cnt, tmo_n;
    logic            busy_n, done_n, err_n, clk_oe_n, data_oe_n;

    logic clk_lvl, clk_fe;
    logic data_lvl, data_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clock   (clock),
        .reset   (reset),
        .line_in (ps2_clk_in),
        .level   (clk_lvl),
        .fall    (clk_fe)
    );

    ps2_sync_edge u_data_sync (
        .clock   (clock),
        .reset   (reset),
        .line_in (ps2_data_in),
        .level   (data_lvl),
        .fall    (data_fall_unused)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            parity      <= 1'b0;
            bitcnt      <= '0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            parity      <= parity_n;
            bitcnt      <= bitcnt_n;
            inh_cnt     <= inh_n;
            tmo_cnt     <= tmo_n;
            tx_busy     <= busy_n;
            tx_done     <= done_n;
            tx_error    <= err_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        parity_n  = parity;
        bitcnt_n  = bitcnt;
        inh_n     = inh_cnt;
        tmo_n     = tmo_cnt;
        busy_n    = tx_busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;

        case (state)
            IDLE: begin
                busy_n    = 1'b0;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_start) begin
                    shreg_n   = tx_data;
                    parity_n  = odd_parity(tx_data);
                    inh_n     = '0;
                    busy_n    = 1'b1;
                    clk_oe_n  = 1'b1;
                    data_oe_n = (INHIBIT_CYCLES == 1);
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_n = inh_cnt + IW'(1);
                // Registered outputs: decide one cycle ahead so data_oe rises on the last inhibit cycle.
                if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) data_oe_n = 1'b1;
                if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_n = 1'b0;
                    state_n  = RTS;
                end
            end
            RTS: begin
                bitcnt_n = '0;
                tmo_n    = '0;
                state_n  = SHIFT;
            end
            SHIFT, ACK, WAIT_IDLE: begin
                tmo_n = tmo_cnt + TW'(1);
                if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n   = IDLE;
                    err_n     = 1'b1;
                    busy_n    = 1'b0;
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                end else if (state == SHIFT) begin
                    if (clk_fe) begin
                        if (bitcnt < 4'd8) data_oe_n = ~shreg[bitcnt[2:0]];
                        else if (bitcnt == 4'd8) data_oe_n = ~parity;
                        else data_oe_n = 1'b0;
                        bitcnt_n = bitcnt + 4'd1;
                        if (bitcnt == 4'(FRAME_BITS - 2)) state_n = ACK;
                    end
                end else if (state == ACK) begin
                    if (clk_fe) begin
                        if (!data_lvl) begin
                            state_n = WAIT_IDLE;
                        end else begin
                            state_n = IDLE;
                            err_n   = 1'b1;
                            busy_n  = 1'b0;
                        end
                    end
                end else begin
                    if (clk_lvl && data_lvl) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                busy_n    = 1'b0;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_modulo_ps2_tx.sv
// Directed bench for modulo_ps2_tx with a wired-AND PS/2 device model.
module tb_modulo_ps2_tx;
    import modulo_ps2_tx_pkg::*;

    localparam int unsigned INH  = 100;
    localparam int unsigned TMO  = 20000;
    localparam int unsigned HALF = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_high = 1'b1;
    logic       dev_data_low = 1'b0;

    int tests = 0;
    int fails = 0;
    int ndone, nerr, busy_gap;
    logic in_frame = 1'b0;
    logic err_clk_oe, err_data_oe;
    logic [10:0] got;

    always #5 clock = ~clock;

    assign ps2_clk_in  = dev_clk_high & ~ps2_clk_oe;
    assign ps2_data_in = ~dev_data_low & ~ps2_data_oe;

    modulo_ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        if (tx_done) ndone++;
        if (tx_error) begin
            nerr++;
            err_clk_oe  = ps2_clk_oe;
            err_data_oe = ps2_data_oe;
        end
        if (tx_done || tx_error) in_frame = 1'b0;
        else if (in_frame && !tx_busy) busy_gap++;
    endtask

    // Issue a start, then check acceptance and the inhibit / request-to-send window.
    task automatic request(input logic [7:0] d);
        int cnt;
        int first;
        tx_data  = d;
        tx_start = 1'b1;
        ndone = 0; nerr = 0; busy_gap = 0;
        step();
        tx_start = 1'b0;
        in_frame = 1'b1;
        chk("accept_busy", 32'(tx_busy), 32'd1);
        chk("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
        cnt = 0; first = 0;
        while (ps2_clk_oe && cnt < 1000) begin
            cnt++;
            if (ps2_data_oe && first == 0) first = cnt;
            step();
        end
        chk("inhibit_len", 32'(cnt), 32'(INH));
        chk("data_oe_rise", 32'(first), 32'(INH));
        chk("rts_data_oe", 32'(ps2_data_oe), 32'd1);
    endtask

    // Device: samples start, then 10 bits on rising edges, then an 11th clock for ACK.
    task automatic device(input logic nack, input int reset_at, output logic [10:0] g);
        logic held;
        held = 1'b1;
        g = '0;
        repeat (20) begin
            step();
            if (!ps2_data_oe || ps2_clk_oe) held = 1'b0;
        end
        chk("start_held", 32'(held), 32'd1);
        g[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_high = 1'b0;
            if (i == reset_at) begin
                repeat (10) step();
                in_frame = 1'b0;
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk("rst_busy", 32'(tx_busy), 32'd0);
                chk("rst_done", 32'(tx_done), 32'd0);
                chk("rst_error", 32'(tx_error), 32'd0);
                chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
                chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
                chk("rst_state", 32'(dut.state), 32'(IDLE));
                dev_clk_high = 1'b1;
                repeat (10) step();
                return;
            end
            repeat (HALF) step();
            dev_clk_high = 1'b1;
            g[i] = ps2_data_in;
            repeat (HALF) step();
        end
        dev_clk_high = 1'b0;
        dev_data_low = ~nack;
        repeat (HALF) step();
        dev_clk_high = 1'b1;
        repeat (10) step();
        dev_data_low = 1'b0;
        repeat (20) step();
    endtask

    task automatic frame_checks(input logic [7:0] d, input logic par, input logic [10:0] g);
        chk($sformatf("start_%02h", d), 32'(g[0]), 32'd0);
        chk($sformatf("data_%02h", d), 32'(g[8:1]), 32'(d));
        chk($sformatf("parity_%02h", d), 32'(g[9]), 32'(par));
        chk($sformatf("stop_%02h", d), 32'(g[10]), 32'd1);
    endtask

    task automatic ack_checks(input logic [7:0] d);
        chk($sformatf("done_%02h", d), 32'(ndone), 32'd1);
        chk($sformatf("noerr_%02h", d), 32'(nerr), 32'd0);
        chk($sformatf("busy_span_%02h", d), 32'(busy_gap), 32'd0);
        chk($sformatf("busy_end_%02h", d), 32'(tx_busy), 32'd0);
    endtask

    initial begin
        int n;
        step();
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_done", 32'(tx_done), 32'd0);
        chk("reset_error", 32'(tx_error), 32'd0);
        chk("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        step();
        reset = 1'b0;
        repeat (5) step();

        request(8'hED); device(1'b0, 0, got); frame_checks(8'hED, 1'b1, got); ack_checks(8'hED);
        request(8'h01); device(1'b0, 0, got); frame_checks(8'h01, 1'b0, got); ack_checks(8'h01);
        request(8'hFF); device(1'b0, 0, got); frame_checks(8'hFF, 1'b1, got); ack_checks(8'hFF);
        request(8'h00); device(1'b0, 0, got); frame_checks(8'h00, 1'b1, got); ack_checks(8'h00);

        // NACK: device leaves data high on the 11th clock.
        request(8'h5A); device(1'b1, 0, got); frame_checks(8'h5A, 1'b1, got);
        chk("nack_error", 32'(nerr), 32'd1);
        chk("nack_done", 32'(ndone), 32'd0);
        chk("nack_clk_oe", 32'(err_clk_oe), 32'd0);
        chk("nack_data_oe", 32'(err_data_oe), 32'd0);
        chk("nack_clk_oe_after", 32'(ps2_clk_oe), 32'd0);
        chk("nack_data_oe_after", 32'(ps2_data_oe), 32'd0);

        // Timeout: device never clocks; error lands TMO cycles after the RTS cycle ends.
        request(8'hF0);
        n = 0;
        while (nerr == 0 && n < 25000) begin
            if (n == 50) begin
                tx_data  = 8'h3C;
                tx_start = 1'b1;
            end
            step();
            n++;
            if (n == 51) begin
                tx_start = 1'b0;
                chk("midstart_busy", 32'(tx_busy), 32'd1);
                chk("midstart_clk_oe", 32'(ps2_clk_oe), 32'd0);
                chk("midstart_shreg", 32'(dut.shreg), 32'h0F0);
            end
        end
        chk("timeout_cycles", 32'(n), 32'(TMO + 1));
        chk("timeout_clk_oe", 32'(err_clk_oe), 32'd0);
        chk("timeout_data_oe", 32'(err_data_oe), 32'd0);
        chk("timeout_done", 32'(ndone), 32'd0);
        step();
        chk("timeout_busy_after", 32'(tx_busy), 32'd0);

        // Reset during bit 4 of 0xED, then a clean 0xF4.
        request(8'hED); device(1'b0, 5, got);
        request(8'hF4); device(1'b0, 0, got); frame_checks(8'hF4, 1'b0, got); ack_checks(8'hF4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
